// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART rx state type, frame width and default link rates.
// UART_RX_MAJORITY_VOTE_EN moves the per-bit decision from sample 7 to sample 8.
package uart_pkg;

  localparam int UART_CLK_HZ      = 25000000;
  localparam int UART_BAUD_RATE   = 9600;
  localparam int UART_SAMPLE_RATE = 16;
  localparam int UART_DATA_W      = 9;

  localparam logic [3:0] RX_LAST_BIT = 4'(UART_DATA_W - 1);
  localparam logic [3:0] RX_WRAP_IDX = 4'd15;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] RX_DECIDE_IDX = 4'd8;
`else
  localparam logic [3:0] RX_DECIDE_IDX = 4'd7;
`endif

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - frame sequencing for the UART receiver.
// Turns decision/wrap ticks into counter, shift and strobe controls.
module uart_rx_fsm
  import uart_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_i,
  input  logic [3:0] sample_cnt_i,
  input  logic [3:0] bit_cnt_i,
  input  logic       bit_i,
  input  logic       rx_s_i,
  input  logic       start_edge_i,
  output logic       cnt_clear_o,
  output logic       bit_clear_o,
  output logic       bit_inc_o,
  output logic       shift_en_o,
  output logic       load_data_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  rx_state_e state_q, state_d;
  logic      decide;
  logic      wrap;

  assign decide = tick_i && (sample_cnt_i == RX_DECIDE_IDX);
  assign wrap   = tick_i && (sample_cnt_i == RX_WRAP_IDX);
  assign busy_o = (state_q != RX_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_clear_o = 1'b0;
    bit_clear_o = 1'b0;
    bit_inc_o   = 1'b0;
    shift_en_o  = 1'b0;
    load_data_o = 1'b0;
    frame_err_o = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (start_edge_i) begin
          state_d     = RX_START;
          cnt_clear_o = 1'b1;
        end
      end
      RX_START: begin
        if (decide && bit_i) begin
          state_d = RX_IDLE;
        end else if (wrap) begin
          state_d     = RX_DATA;
          bit_clear_o = 1'b1;
        end
      end
      RX_DATA: begin
        shift_en_o = decide;
        if (wrap) begin
          if (bit_cnt_i == RX_LAST_BIT) begin
            state_d = RX_STOP;
          end else begin
            bit_inc_o = 1'b1;
          end
        end
      end
      RX_STOP: begin
        // Decide mid stop bit so a slightly fast sender can start its next frame early.
        if (decide) begin
          if (bit_i) begin
            load_data_o = 1'b1;
            state_d     = RX_IDLE;
          end else begin
            frame_err_o = 1'b1;
            state_d     = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (rx_s_i) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled receiver for 9-bit UART frames (8N1-style, 9 data bits).
// UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote over samples 6, 7 and 8.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = UART_CLK_HZ,
  parameter int BAUD_RATE   = UART_BAUD_RATE,
  parameter int SAMPLE_RATE = UART_SAMPLE_RATE
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] data,
  output logic                   data_valid,
  output logic                   framing_error,
  output logic                   busy
);

  localparam int DIVISOR = CLK_HZ / (BAUD_RATE * SAMPLE_RATE);
  localparam int DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);

  logic                   rx_meta_q, rx_s_q, rx_s_d_q;
  logic [2:0]             fill_q;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [3:0]             sample_cnt_q, sample_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   data_valid_q, framing_error_q;

  logic tick, start_edge, rx_bit;
  logic cnt_clear, bit_clear, bit_inc, shift_en, load_data, frame_err;

  // fill_q marks when rx_s_d_q holds a real pin sample, so a line held low
  // through reset release is not mistaken for a start edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_s_d_q  <= 1'b1;
      fill_q    <= 3'b000;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_s_d_q  <= rx_s_q;
      fill_q    <= {fill_q[1:0], 1'b1};
    end
  end

  assign start_edge = fill_q[2] && rx_s_d_q && !rx_s_q;
  assign tick       = (div_q == DIV_LAST);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic vote6_q, vote7_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vote6_q <= 1'b0;
      vote7_q <= 1'b0;
    end else if (tick) begin
      if (sample_cnt_q == 4'd6) vote6_q <= rx_s_q;
      if (sample_cnt_q == 4'd7) vote7_q <= rx_s_q;
    end
  end

  assign rx_bit = (vote6_q & vote7_q) | (vote6_q & rx_s_q) | (vote7_q & rx_s_q);
`else
  assign rx_bit = rx_s_q;
`endif

  always_comb begin
    div_d        = div_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    if (cnt_clear || tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
    if (cnt_clear) begin
      sample_cnt_d = 4'd0;
    end else if (tick) begin
      sample_cnt_d = sample_cnt_q + 4'd1;
    end
    if (bit_clear) begin
      bit_cnt_d = 4'd0;
    end else if (bit_inc) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
    end
    if (shift_en) begin
      shift_d = {rx_bit, shift_q[UART_DATA_W-1:1]};
    end
    if (load_data) begin
      data_d = shift_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q           <= '0;
      sample_cnt_q    <= 4'd0;
      bit_cnt_q       <= 4'd0;
      shift_q         <= '0;
      data_q          <= '0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      div_q           <= div_d;
      sample_cnt_q    <= sample_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      data_q          <= data_d;
      data_valid_q    <= load_data;
      framing_error_q <= frame_err;
    end
  end

  uart_rx_fsm u_fsm (
    .clock        (clock),
    .reset        (reset),
    .tick_i       (tick),
    .sample_cnt_i (sample_cnt_q),
    .bit_cnt_i    (bit_cnt_q),
    .bit_i        (rx_bit),
    .rx_s_i       (rx_s_q),
    .start_edge_i (start_edge),
    .cnt_clear_o  (cnt_clear),
    .bit_clear_o  (bit_clear),
    .bit_inc_o    (bit_inc),
    .shift_en_o   (shift_en),
    .load_data_o  (load_data),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
  );

  assign data          = data_q;
  assign data_valid    = data_valid_q;
  assign framing_error = framing_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a fast divisor.
// Expectations for the glitch case follow UART_RX_MAJORITY_VOTE_EN.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BAUD   = 9600;
  localparam int DIV    = 5;
  localparam int CLK_HZ = BAUD * 16 * DIV;
  localparam int BITC   = 16 * DIV;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int BUSY_CYC = 169 * DIV;
`else
  localparam int BUSY_CYC = 168 * DIV;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [8:0] data;
  logic       data_valid, framing_error, busy;

  int         errors = 0;
  int         checks = 0;
  int         fe_cnt = 0;
  logic [8:0] rcv_q[$];
  logic [8:0] exp_data = 9'h000;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .SAMPLE_RATE(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .rx            (rx),
    .data          (data),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset) begin
      if (data_valid) rcv_q.push_back(data);
      if (framing_error) fe_cnt++;
      if (data_valid || framing_error) begin
        checks++;
        if (data_valid && framing_error) begin
          $display("FAIL strobe_exclusive: data_valid=1 framing_error=1, required at most one high");
          errors++;
        end
      end
    end
  end

  // Pin level for cycle c of a frame: start, 9 data bits LSB first, optional low stop bits, one high stop bit.
  task automatic send_frame(input logic [8:0] w, input int stop_low, input int glo, input int ghi);
    int   n;
    int   b;
    logic lv;
    n = (11 + stop_low) * BITC;
    for (int c = 0; c < n; c++) begin
      b = c / BITC;
      if (b == 0) lv = 1'b0;
      else if (b <= 9) lv = w[b-1];
      else lv = ((b - 10) < stop_low) ? 1'b0 : 1'b1;
      if (c >= glo && c <= ghi) lv = 1'b1;
      @(negedge clock);
      rx = lv;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (data !== 9'h000) begin $display("FAIL reset_data: got %h want 000", data); errors++; end
    checks++; if (data_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", data_valid); errors++; end
    checks++; if (framing_error !== 1'b0) begin $display("FAIL reset_ferr: got %b want 0", framing_error); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); errors++; end
    reset = 1'b0;
    repeat (10) @(negedge clock);
    checks++; if (busy !== 1'b0) begin $display("FAIL idle_busy: got %b want 0", busy); errors++; end
  endtask

  task automatic test_good_frame();
    int         fe0;
    int         bcnt;
    logic [8:0] got;
    rcv_q.delete();
    fe0  = fe_cnt;
    bcnt = 0;
    fork
      send_frame(9'h1A5, 0, -1, -1);
      begin
        for (int i = 0; i < 11 * BITC - 2; i++) begin
          @(negedge clock);
          if (busy) bcnt++;
        end
      end
    join
    repeat (2) @(negedge clock);
    exp_data = 9'h1A5;
    got = (rcv_q.size() > 0) ? rcv_q[0] : 9'bx;
    checks++; if (rcv_q.size() != 1) begin $display("FAIL good_count: got %0d want 1", rcv_q.size()); errors++; end
    checks++; if (got !== 9'h1A5) begin $display("FAIL good_word: got %h want 1a5", got); errors++; end
    checks++; if (data !== exp_data) begin $display("FAIL good_data: got %h want %h", data, exp_data); errors++; end
    checks++; if (fe_cnt != fe0) begin $display("FAIL good_ferr: got %0d want 0", fe_cnt - fe0); errors++; end
    checks++;
    if (bcnt < BUSY_CYC - 2 || bcnt > BUSY_CYC + 2) begin
      $display("FAIL good_busy_len: got %0d want %0d", bcnt, BUSY_CYC); errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] g0, g1;
    rcv_q.delete();
    send_frame(9'h000, 0, -1, -1);
    send_frame(9'h1FF, 0, -1, -1);
    repeat (2) @(negedge clock);
    exp_data = 9'h1FF;
    g0 = (rcv_q.size() > 0) ? rcv_q[0] : 9'bx;
    g1 = (rcv_q.size() > 1) ? rcv_q[1] : 9'bx;
    checks++; if (rcv_q.size() != 2) begin $display("FAIL b2b_count: got %0d want 2", rcv_q.size()); errors++; end
    checks++; if (g0 !== 9'h000) begin $display("FAIL b2b_first: got %h want 000", g0); errors++; end
    checks++; if (g1 !== 9'h1FF) begin $display("FAIL b2b_second: got %h want 1ff", g1); errors++; end
  endtask

  task automatic test_start_glitch();
    int   fe0;
    logic seen;
    rcv_q.delete();
    fe0  = fe_cnt;
    seen = 1'b0;
    for (int c = 0; c < 4 * DIV; c++) begin
      @(negedge clock);
      rx = 1'b0;
      if (busy) seen = 1'b1;
    end
    for (int c = 0; c < 2 * BITC; c++) begin
      @(negedge clock);
      rx = 1'b1;
      if (busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin $display("FAIL glitch_busy_seen: got %b want 1", seen); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL glitch_busy_end: got %b want 0", busy); errors++; end
    checks++; if (rcv_q.size() != 0) begin $display("FAIL glitch_valid: got %0d want 0", rcv_q.size()); errors++; end
    checks++; if (fe_cnt != fe0) begin $display("FAIL glitch_ferr: got %0d want 0", fe_cnt - fe0); errors++; end
    checks++; if (data !== exp_data) begin $display("FAIL glitch_data: got %h want %h", data, exp_data); errors++; end
  endtask

  task automatic test_framing_error();
    int         fe0;
    logic       brk_busy;
    logic [8:0] got;
    rcv_q.delete();
    fe0 = fe_cnt;
    brk_busy = 1'b0;
    fork
      send_frame(9'h0F0, 2, -1, -1);
      begin
        repeat (11 * BITC + BITC / 2) @(negedge clock);
        brk_busy = busy;
      end
    join
    repeat (2) @(negedge clock);
    checks++; if (fe_cnt - fe0 != 1) begin $display("FAIL fe_count: got %0d want 1", fe_cnt - fe0); errors++; end
    checks++; if (rcv_q.size() != 0) begin $display("FAIL fe_valid: got %0d want 0", rcv_q.size()); errors++; end
    checks++; if (data !== exp_data) begin $display("FAIL fe_data_hold: got %h want %h", data, exp_data); errors++; end
    checks++; if (brk_busy !== 1'b1) begin $display("FAIL fe_break_busy: got %b want 1", brk_busy); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL fe_busy_end: got %b want 0", busy); errors++; end
    rcv_q.delete();
    send_frame(9'h055, 0, -1, -1);
    repeat (2) @(negedge clock);
    exp_data = 9'h055;
    got = (rcv_q.size() > 0) ? rcv_q[0] : 9'bx;
    checks++; if (rcv_q.size() != 1) begin $display("FAIL fe_next_count: got %0d want 1", rcv_q.size()); errors++; end
    checks++; if (got !== 9'h055) begin $display("FAIL fe_next_word: got %h want 055", got); errors++; end
  endtask

  task automatic test_reset_midframe();
    int         fe0;
    logic [8:0] got;
    rcv_q.delete();
    fe0 = fe_cnt;
    fork
      send_frame(9'h00F, 0, -1, -1);
      begin
        repeat (5 * BITC + BITC / 2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if (data !== 9'h000) begin $display("FAIL rst_data: got %h want 000", data); errors++; end
        checks++; if (data_valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", data_valid); errors++; end
        checks++; if (framing_error !== 1'b0) begin $display("FAIL rst_ferr: got %b want 0", framing_error); errors++; end
        checks++; if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); errors++; end
        reset = 1'b0;
      end
    join
    repeat (4) @(negedge clock);
    exp_data = 9'h000;
    checks++; if (rcv_q.size() != 0) begin $display("FAIL rst_tail_valid: got %0d want 0", rcv_q.size()); errors++; end
    checks++; if (fe_cnt != fe0) begin $display("FAIL rst_tail_ferr: got %0d want 0", fe_cnt - fe0); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL rst_tail_busy: got %b want 0", busy); errors++; end
    send_frame(9'h123, 0, -1, -1);
    repeat (2) @(negedge clock);
    exp_data = 9'h123;
    got = (rcv_q.size() > 0) ? rcv_q[0] : 9'bx;
    checks++; if (rcv_q.size() != 1) begin $display("FAIL rst_next_count: got %0d want 1", rcv_q.size()); errors++; end
    checks++; if (got !== 9'h123) begin $display("FAIL rst_next_word: got %h want 123", got); errors++; end
  endtask

  task automatic test_random();
    logic [8:0] exp_q[$];
    logic [8:0] w;
    logic [8:0] got;
    int         gap;
    int         fe0;
    rcv_q.delete();
    fe0 = fe_cnt;
    for (int i = 0; i < 10; i++) begin
      w   = 9'($urandom_range(0, 511));
      gap = $urandom_range(0, 2 * BITC);
      exp_q.push_back(w);
      send_frame(w, 0, -1, -1);
      repeat (gap) @(negedge clock);
    end
    repeat (2) @(negedge clock);
    exp_data = exp_q[exp_q.size()-1];
    checks++; if (rcv_q.size() != exp_q.size()) begin $display("FAIL rand_count: got %0d want %0d", rcv_q.size(), exp_q.size()); errors++; end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rcv_q.size()) ? rcv_q[i] : 9'bx;
      checks++;
      if (got !== exp_q[i]) begin $display("FAIL rand_word[%0d]: got %h want %h", i, got, exp_q[i]); errors++; end
    end
    checks++; if (fe_cnt != fe0) begin $display("FAIL rand_ferr: got %0d want 0", fe_cnt - fe0); errors++; end
    checks++; if (data !== exp_data) begin $display("FAIL rand_data: got %h want %h", data, exp_data); errors++; end
  endtask

  task automatic test_vote_glitch();
    logic [8:0] want;
    logic [8:0] got;
`ifdef UART_RX_MAJORITY_VOTE_EN
    want = 9'h000;
`else
    want = 9'h001;
`endif
    rcv_q.delete();
    // One-tick high pulse centred on sample 7 of data bit 0.
    send_frame(9'h000, 0, 24 * DIV - 2, 24 * DIV + 2);
    repeat (2) @(negedge clock);
    got = (rcv_q.size() > 0) ? rcv_q[0] : 9'bx;
    checks++; if (rcv_q.size() != 1) begin $display("FAIL vote_count: got %0d want 1", rcv_q.size()); errors++; end
    checks++; if (got !== want) begin $display("FAIL vote_word: got %h want %h", got, want); errors++; end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_start_glitch();
    test_framing_error();
    test_reset_midframe();
    test_random();
    test_vote_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
